// File: rtl/spi_reg_writer_if.sv
// -----------------------------------------------------------------------------
// spi_reg_writer_if
//
// Bundles the request handshake and the three-wire SPI bus of spi_reg_writer.
//
// Handshake: the requester raises start together with rw/addr/wdata. A request
// is taken on a rising clk edge where start=1 and busy=0; the fields are
// captured on that edge. A request seen while busy=1 is dropped, not queued.
// done pulses for one cycle when the frame and its gap are over, and in that
// same cycle busy=0, so a start held high is accepted immediately again.
//
// Signals:
//   start, rw, addr[6:0], wdata[7:0]  requester -> controller
//   busy, done                        controller -> requester
//   SCLK, COPI, nCS                   controller -> peripheral
//   state[2:0]                        controller FSM state, debug visibility
//   CIPO, rdata[7:0]                  only with SPI_READBACK_EN defined
// -----------------------------------------------------------------------------
interface spi_reg_writer_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       SCLK;
    logic       COPI;
    logic       nCS;
    logic [2:0] state;
`ifdef SPI_READBACK_EN
    logic       CIPO;
    logic [7:0] rdata;

    modport master (
        output start, rw, addr, wdata, CIPO,
        input  busy, done, SCLK, COPI, nCS, state, rdata
    );
    modport slave (
        input  start, rw, addr, wdata, CIPO,
        output busy, done, SCLK, COPI, nCS, state, rdata
    );
`else
    modport master (
        output start, rw, addr, wdata,
        input  busy, done, SCLK, COPI, nCS, state
    );
    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, SCLK, COPI, nCS, state
    );
`endif
endinterface

// File: rtl/spi_reg_writer.sv
// -----------------------------------------------------------------------------
// spi_reg_writer
//
// SPI mode-0 controller issuing 16-bit register frames {rw, addr[6:0],
// wdata[7:0]}, MSB first. SCLK is derived from clk with a half-period of
// CLK_DIV cycles; nCS stays high at least GAP_CYCLES cycles between frames.
//
// Optional feature macro: SPI_READBACK_EN. When defined, CIPO is sampled on
// SCLK rises 9..16 and the byte is published on rdata at the end of each
// rw=0 frame. When undefined, there is no readback logic at all.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    spi_reg_writer_if.slave: start/rw/addr/wdata in, busy/done out,
//          SCLK/COPI/nCS out, state (debug) out, CIPO in / rdata out (option)
//
// Every output is a flop. The FSM computes next-state and the next value of
// each output together, so outputs reflect a state change on the same edge
// the state register takes it: an accept on edge 0 shows nCS=0 in cycle 1.
// -----------------------------------------------------------------------------
module spi_reg_writer #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_reg_writer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Down-counter reload values. The GAP state covers GAP_CYCLES-1 cycles;
    // the last gap cycle is the IDLE cycle carrying done.
    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 1) ? 8'(GAP_CYCLES - 2) : 8'd0;
    localparam logic [3:0] LAST_BIT = 4'd15;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t      state, state_n;
    logic [7:0]  div_cnt, div_cnt_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [15:0] shreg, shreg_n;
    logic        rw_q, rw_n;
    logic        sclk_q, sclk_n;
    logic        copi_q, copi_n;
    logic        ncs_q, ncs_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;

    // Event strobes used by the readback path
    logic        sample_cipo;
    logic        finish_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= 8'd0;
            bit_cnt <= 4'd0;
            shreg   <= 16'd0;
            rw_q    <= 1'b0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            rw_q    <= rw_n;
            sclk_q  <= sclk_n;
            copi_q  <= copi_n;
            ncs_q   <= ncs_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n      = state;
        div_cnt_n    = div_cnt;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        rw_n         = rw_q;
        sclk_n       = sclk_q;
        copi_n       = copi_q;
        ncs_n        = ncs_q;
        done_n       = 1'b0;
        sample_cipo  = 1'b0;
        finish_frame = 1'b0;

        case (state)
            IDLE: begin
                sclk_n = 1'b0;
                copi_n = 1'b0;
                ncs_n  = 1'b1;
                if (bus.start) begin
                    state_n   = SETUP;
                    shreg_n   = {bus.rw, bus.addr, bus.wdata};
                    rw_n      = bus.rw;
                    bit_cnt_n = LAST_BIT;
                    div_cnt_n = DIV_LOAD;
                    ncs_n     = 1'b0;
                    copi_n    = bus.rw;
                end
            end

            SETUP: begin
                if (div_cnt == 8'd0) begin
                    // First rise; bit_cnt is 15 so no readback sample here.
                    state_n   = SHIFT;
                    sclk_n    = 1'b1;
                    div_cnt_n = DIV_LOAD;
                end else begin
                    div_cnt_n = div_cnt - 8'd1;
                end
            end

            SHIFT: begin
                if (div_cnt == 8'd0) begin
                    div_cnt_n = DIV_LOAD;
                    if (!sclk_q) begin
                        // Rise k happens with bit_cnt = 16-k, so rises 9..16
                        // are exactly those with bit_cnt in 7..0.
                        sclk_n      = 1'b1;
                        sample_cipo = ~bit_cnt[3];
                    end else begin
                        sclk_n = 1'b0;
                        if (bit_cnt == 4'd0) begin
                            // Fall after the 16th rise closes the data phase.
                            state_n = HOLD;
                            copi_n  = 1'b0;
                        end else begin
                            shreg_n   = {shreg[14:0], 1'b0};
                            copi_n    = shreg[14];
                            bit_cnt_n = bit_cnt - 4'd1;
                        end
                    end
                end else begin
                    div_cnt_n = div_cnt - 8'd1;
                end
            end

            HOLD: begin
                if (div_cnt == 8'd0) begin
                    ncs_n = 1'b1;
                    if (GAP_CYCLES == 1) begin
                        // The single gap cycle is also the done cycle.
                        state_n      = IDLE;
                        done_n       = 1'b1;
                        finish_frame = 1'b1;
                    end else begin
                        state_n   = GAP;
                        div_cnt_n = GAP_LOAD;
                    end
                end else begin
                    div_cnt_n = div_cnt - 8'd1;
                end
            end

            GAP: begin
                if (div_cnt == 8'd0) begin
                    state_n      = IDLE;
                    done_n       = 1'b1;
                    finish_frame = 1'b1;
                end else begin
                    div_cnt_n = div_cnt - 8'd1;
                end
            end

            default: begin
                state_n = IDLE;
                sclk_n  = 1'b0;
                copi_n  = 1'b0;
                ncs_n   = 1'b1;
            end
        endcase
    end

    // busy follows the state the FSM is entering, which makes it drop in the
    // done cycle and rise in the cycle nCS falls.
    assign busy_n = (state_n != IDLE);

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.SCLK  = sclk_q;
    assign bus.COPI  = copi_q;
    assign bus.nCS   = ncs_q;
    assign bus.state = state;

    // -------------------------------------------------------------------------
    // Optional readback of the peripheral's CIPO byte
    // -------------------------------------------------------------------------
`ifdef SPI_READBACK_EN
    logic [7:0] stage;
    logic [7:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage   <= 8'd0;
            rdata_q <= 8'd0;
        end else begin
            if (sample_cipo) begin
                stage <= {stage[6:0], bus.CIPO};
            end
            // Only read frames publish; write frames leave rdata untouched.
            if (finish_frame && !rw_q) begin
                rdata_q <= stage;
            end
        end
    end

    assign bus.rdata = rdata_q;
`else
    logic unused_readback;
    assign unused_readback = sample_cipo ^ finish_frame ^ rw_q;
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_writer
//
// Directed bench for spi_reg_writer with default parameters (CLK_DIV=4,
// GAP_CYCLES=8). Cycle 0 is the cycle in which start is presented; all bus
// observations are taken on the falling clk edge and timed relative to it.
// -----------------------------------------------------------------------------
module tb_spi_reg_writer;

    logic clk;
    logic rst_n;

    spi_reg_writer_if bus ();

    spi_reg_writer #(
        .CLK_DIV   (4),
        .GAP_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] exp_frame;
        int          exp_first_rise;
        int          exp_ncs_rise;
        int          exp_done;
    } vec_t;

    vec_t vecs[5];

    // ---------------- scoreboard state ----------------
    int n_vec;
    int n_miss;

    int rel;
    logic prev_sclk;
    logic prev_ncs;
    int rises;
    logic [15:0] shifted;
    int done_busy_bad;
    int fall_t[$];
    int rise_t[$];
    int done_t[$];
    int first_t[$];
    int nrise_q[$];
    int frame_q[$];
`ifdef SPI_READBACK_EN
    logic [15:0] cipo_word;
    int cipo_idx;
    int rdata_at_done;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_log();
        fall_t.delete();
        rise_t.delete();
        done_t.delete();
        first_t.delete();
        nrise_q.delete();
        frame_q.delete();
        rises         = 0;
        shifted       = 16'd0;
        done_busy_bad = 0;
        prev_sclk     = bus.SCLK;
        prev_ncs      = bus.nCS;
    endtask

    // Observe one falling-edge snapshot of the bus.
    task automatic sample();
        if (prev_ncs && !bus.nCS) begin
            fall_t.push_back(rel);
            rises   = 0;
            shifted = 16'd0;
`ifdef SPI_READBACK_EN
            cipo_idx = 15;
            bus.CIPO = cipo_word[15];
`endif
        end
        if (bus.SCLK && !prev_sclk) begin
            rises++;
            shifted = {shifted[14:0], bus.COPI};
            if (rises == 1) first_t.push_back(rel);
        end
`ifdef SPI_READBACK_EN
        // Mode-0 peripheral: next bit appears on each SCLK fall.
        if (!bus.SCLK && prev_sclk && cipo_idx > 0) begin
            cipo_idx--;
            bus.CIPO = cipo_word[cipo_idx];
        end
`endif
        if (!prev_ncs && bus.nCS) begin
            rise_t.push_back(rel);
            frame_q.push_back(int'(shifted));
            nrise_q.push_back(rises);
        end
        if (bus.done) begin
            done_t.push_back(rel);
            if (bus.busy) done_busy_bad++;
`ifdef SPI_READBACK_EN
            rdata_at_done = int'(bus.rdata);
`endif
        end
        prev_sclk = bus.SCLK;
        prev_ncs  = bus.nCS;
    endtask

    task automatic step();
        @(negedge clk);
        rel++;
        sample();
    endtask

    // Present a request in cycle 0, release it in cycle 1, and scramble the
    // request fields so a design that re-reads them mid-frame is exposed.
    task automatic launch(input logic rw, input logic [6:0] addr, input logic [7:0] wdata);
        @(negedge clk);
        clear_log();
        rel       = 0;
        bus.rw    = rw;
        bus.addr  = addr;
        bus.wdata = wdata;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.rw    = ~rw;
        bus.addr  = ~addr;
        bus.wdata = ~wdata;
    endtask

    task automatic run_to(input int last_rel);
        while (rel < last_rel) step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int idle_bad;
        n_vec  = 0;
        n_miss = 0;
        rel    = 0;

        vecs[0] = '{1'b1, 7'h04, 8'h80, 16'h8480, 5, 133, 140};
        vecs[1] = '{1'b1, 7'h7F, 8'hFF, 16'hFFFF, 5, 133, 140};
        vecs[2] = '{1'b0, 7'h02, 8'h55, 16'h0255, 5, 133, 140};
        vecs[3] = '{1'b1, 7'h00, 8'h00, 16'h8000, 5, 133, 140};
        vecs[4] = '{1'b1, 7'h2A, 8'hC3, 16'hAAC3, 5, 133, 140};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = 7'd0;
        bus.wdata = 8'd0;
`ifdef SPI_READBACK_EN
        bus.CIPO  = 1'b0;
        cipo_word = 16'h0000;
        cipo_idx  = 15;
        rdata_at_done = -1;
`endif

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ncs",   int'(bus.nCS),  1);
        chk("rst_sclk",  int'(bus.SCLK), 0);
        chk("rst_copi",  int'(bus.COPI), 0);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_done",  int'(bus.done), 0);
        chk("rst_state", int'(bus.state), 0);
`ifdef SPI_READBACK_EN
        chk("rst_rdata", int'(bus.rdata), 0);
`endif
        rst_n = 1'b1;

        // Idle 50 cycles with no request
        idle_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.nCS !== 1'b1 || bus.SCLK !== 1'b0 || bus.COPI !== 1'b0 ||
                bus.busy !== 1'b0 || bus.done !== 1'b0) idle_bad++;
        end
        chk("idle_50", idle_bad, 0);

        // Table-driven single frames
        for (int v = 0; v < 5; v++) begin
            launch(vecs[v].rw, vecs[v].addr, vecs[v].wdata);
            chk($sformatf("v%0d_busy_c1", v), int'(bus.busy), 1);
            run_to(170);
            chk($sformatf("v%0d_frame", v),     qget(frame_q, 0), int'(vecs[v].exp_frame));
            chk($sformatf("v%0d_rises", v),     qget(nrise_q, 0), 16);
            chk($sformatf("v%0d_ncs_fall", v),  qget(fall_t, 0),  1);
            chk($sformatf("v%0d_first_rise", v), qget(first_t, 0), vecs[v].exp_first_rise);
            chk($sformatf("v%0d_ncs_rise", v),  qget(rise_t, 0),  vecs[v].exp_ncs_rise);
            chk($sformatf("v%0d_done", v),      qget(done_t, 0),  vecs[v].exp_done);
            chk($sformatf("v%0d_done_count", v), done_t.size(), 1);
            chk($sformatf("v%0d_done_busy", v), done_busy_bad,   0);
        end

        // Back-to-back: start held high, addr 0x00 then 0x01
        launch(1'b1, 7'h00, 8'h11);
        bus.start = 1'b1;
        bus.rw    = 1'b1;
        bus.addr  = 7'h01;
        bus.wdata = 8'h22;
        while (rel < 320) begin
            step();
            if (rel == 141) bus.start = 1'b0;
        end
        chk("b2b_frame0",   qget(frame_q, 0), 16'h8011);
        chk("b2b_frame1",   qget(frame_q, 1), 16'h8122);
        chk("b2b_period",   qget(fall_t, 1) - qget(fall_t, 0), 140);
        chk("b2b_gap",      qget(fall_t, 1) - qget(rise_t, 0), 8);
        chk("b2b_done1",    qget(done_t, 1), 280);
        chk("b2b_frames",   frame_q.size(), 2);

        // Start pulsed mid-frame with a different address is dropped
        launch(1'b1, 7'h10, 8'h3C);
        while (rel < 300) begin
            step();
            if (rel == 40) begin
                bus.start = 1'b1;
                bus.addr  = 7'h55;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("drop_frame",  qget(frame_q, 0), 16'h903C);
        chk("drop_frames", frame_q.size(), 1);
        chk("drop_dones",  done_t.size(), 1);
        chk("drop_done_t", qget(done_t, 0), 140);

        // Asynchronous reset in the middle of a frame
        launch(1'b1, 7'h0F, 8'h0F);
        run_to(70);
        chk("mid_ncs_low", int'(bus.nCS), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ncs",  int'(bus.nCS),  1);
        chk("mid_rst_sclk", int'(bus.SCLK), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_copi", int'(bus.COPI), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        rel = 0;
        repeat (20) step();
        chk("mid_no_done", done_t.size(), 0);
        chk("mid_no_fall", fall_t.size(), 0);
        launch(1'b1, 7'h0A, 8'hBC);
        run_to(170);
        chk("post_rst_frame", qget(frame_q, 0), 16'h8ABC);
        chk("post_rst_rises", qget(nrise_q, 0), 16);
        chk("post_rst_done",  qget(done_t, 0),  140);

`ifdef SPI_READBACK_EN
        // Read frame captures the peripheral's low byte
        cipo_word = 16'h00A5;
        launch(1'b0, 7'h02, 8'h00);
        run_to(170);
        chk("rb_frame",     qget(frame_q, 0), 16'h0200);
        chk("rb_rdata_done", rdata_at_done, 8'hA5);
        // A write frame must not disturb rdata
        cipo_word = 16'h003C;
        rdata_at_done = -1;
        launch(1'b1, 7'h03, 8'h01);
        run_to(170);
        chk("rb_write_done", rdata_at_done, 8'hA5);
        chk("rb_write_hold", int'(bus.rdata), 8'hA5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spi_reg_writer.md
# spi_reg_writer

SPI controller that issues 16-bit register-write frames to the chip's SPI register peripheral: one R/W bit, a 7-bit address and 8 data bits, MSB first, SPI mode 0. It lets on-chip logic or a test harness program the output-enable, PWM-enable and duty-cycle registers over the same three-wire bus (SCLK, COPI, nCS) that the peripheral receives on. It generates SCLK by dividing the system clock.

## Interface
Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles. Legal range is 4..255; 4 is the minimum the peripheral's two-flop SCLK synchroniser tolerates.
- GAP_CYCLES, 8: minimum number of clk cycles nCS stays high between frames. Legal range is 1..255.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a frame; accepted only in a cycle where busy=0.
- rw  in  1  frame bit 15 (1=write, 0=read), sampled at accept.
- addr  in  7  frame bits 14:8, sampled at accept.
- wdata  in  8  frame bits 7:0, sampled at accept.
- busy  out  1  high while a frame or inter-frame gap is in progress.
- done  out  1  one-cycle pulse at end of the gap.
- SCLK  out  1  serial clock; idles low.
- COPI  out  1  serial data, controller to peripheral.
- nCS  out  1  chip select, active low.
- CIPO  in  1  only present with SPI_READBACK_EN.
- rdata  out  8  only present with SPI_READBACK_EN.

## Operation
- Reset values: busy=0, done=0, SCLK=0, COPI=0, nCS=1 (and rdata=0). Reset acts immediately, including mid-frame. A partial frame is abandoned, never completed.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: on start=1, latch {rw,addr,wdata} into a 16-bit shift register and a 4-bit bit counter=15, then go to SETUP. Otherwise start is ignored; start while busy=1 is dropped and not queued.
- SETUP: nCS=0, COPI=bit15, SCLK=0 for CLK_DIV cycles.
- SHIFT: SCLK toggles every CLK_DIV cycles, beginning with a rise.
  - The peripheral samples COPI on each SCLK rise.
  - On each SCLK fall, the shift register moves left and COPI presents the next bit.
  - After the 16th rise and its following fall, go to HOLD with COPI=0.
- HOLD: nCS=0, SCLK=0 for CLK_DIV cycles, then nCS=1 and go to GAP.
- GAP: nCS=1 for GAP_CYCLES cycles. In the final gap cycle, done=1, the state returns to IDLE, and busy=0 in that same cycle.
- Back-to-back frames: a start presented in the done cycle is accepted.
- Inputs are ignored after accept, so changing rw/addr/wdata mid-frame has no effect.
- Counters: the 8-bit divider counter reloads at each SCLK edge. The bit counter saturates at 0 and never wraps.

## Timing
- Cycle numbering: start accepted at rising edge of cycle 0, with D=CLK_DIV and G=GAP_CYCLES.
- nCS falls and busy rises at cycle 1, and COPI=bit15 is valid from cycle 1.
- The k-th SCLK rise (k=1..16) is at cycle 1+D+(k-1)·2D. Each fall is D later.
- COPI is stable for D cycles either side of every rise.
- nCS rises at cycle 1+33D.
- done is at cycle 1+33D+G-1. With defaults this is cycle 140.
- Frame period with start held continuously is 33D+G cycles: 140 with defaults.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- Macro: SPI_READBACK_EN.
- Defined:
  - CIPO and rdata ports exist.
  - CIPO is sampled on clk at each SCLK rise for rises 9..16 and shifted MSB-first into a staging register.
  - rdata is updated from staging in the done cycle, for rw=0 frames only.
  - rdata holds its value across write frames and resets to 0.
- Undefined:
  - No CIPO or rdata ports and no staging logic.
  - rw=0 frames are still shifted out normally.

## Test plan
- Reset then idle 50 cycles -> nCS=1, SCLK=0, COPI=0, busy=0, done=0 throughout.
- Write frame, start with rw=1, addr=0x04, wdata=0x80, defaults:
  - The bus carries 16 rises with sampled bits 0x8480.
  - First rise at cycle 5, nCS high at cycle 133, done at cycle 140.
  - A connected SPI peripheral's duty register becomes 0x80.
- Start held high with addr 0x00/0x01 alternating -> two frames, second nCS fall exactly 140 cycles after the first, gap ≥8 cycles.
- start pulsed at cycle 40 of a frame with different addr -> ignored; only one frame observed, no done beyond cycle 140.
- rst_n low at cycle 70 -> same cycle nCS=1, SCLK=0, busy=0; after release, a new start produces a clean full frame.
- With SPI_READBACK_EN: rw=0, addr=0x02, CIPO driving 0xA5 on bits 7:0 -> rdata=0xA5 at done. A following write frame leaves rdata=0xA5.
